// File: rtl/wb_pkg.sv
// Shared definitions for the write-back sequencer: request codes, data-source
// select constants, FSM state encoding and small request classifiers.
package wb_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        OP_ALU   = 4'd0,
        OP_MFLO  = 4'd1,
        OP_MFHI  = 4'd2,
        OP_LW    = 4'd3,
        OP_SHIFT = 4'd4,
        OP_SLT   = 4'd5,
        OP_LUI   = 4'd6,
        OP_JAL   = 4'd7,
        OP_LB    = 4'd8,
        OP_LH    = 4'd9,
        OP_MULT  = 4'd10,
        OP_DIV   = 4'd11
    } wb_op_e;

    // DataSrc_control mux inputs; the select equals the accepted request code
    localparam logic [3:0] DS_ALU   = 4'd0;
    localparam logic [3:0] DS_LO    = 4'd1;
    localparam logic [3:0] DS_HI    = 4'd2;
    localparam logic [3:0] DS_MDR   = 4'd3;
    localparam logic [3:0] DS_SHIFT = 4'd4;
    localparam logic [3:0] DS_SLT   = 4'd5;
    localparam logic [3:0] DS_LUI   = 4'd6;
    localparam logic [3:0] DS_PC4   = 4'd7;
    localparam logic [3:0] DS_MDR_B = 4'd8;
    localparam logic [3:0] DS_MDR_H = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_MEM = 3'd1,
        S_WAIT_MD  = 3'd2,
        S_LAUNCH   = 3'd3,
        S_WRITE    = 3'd4,
        S_FIN      = 3'd5
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == DS_MDR) || (op == DS_MDR_B) || (op == DS_MDR_H);
    endfunction

    function automatic logic is_md_read(input logic [3:0] op);
        return (op == DS_LO) || (op == DS_HI);
    endfunction

endpackage

// File: rtl/wb_wait_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module wb_wait_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: selects the write-back data source, waits out memory or
// mult/div latency, then strobes the register file. WB_MD_TIMEOUT_EN adds a WAIT_MD watchdog.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int MD_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] wb_op,
    input  logic       divisor_zero,
    input  logic       md_busy,
    input  logic       md_done,
    output logic [3:0] data_src,
    output logic       reg_write,
    output logic       md_start,
    output logic       md_is_div,
    output logic       busy,
    output logic       done,
    output logic       exc_div0,
    output logic       exc_illegal
`ifdef WB_MD_TIMEOUT_EN
    , output logic     exc_md_timeout
`endif
);

    state_e     state, nxt;
    logic [3:0] op_q;
    logic       md_start_q, md_is_div_q, exc_div0_q, exc_ill_q;
    logic       accept, mem_zero, md_exit, wd_expire, exc_pend;

    assign accept  = (state == S_IDLE) && start;
    assign md_exit = is_md_read(op_q) ? !md_busy : md_done;

    wb_wait_counter #(.W(CNT_W)) u_mem_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && is_load(wb_op)),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .dec      (state == S_WAIT_MEM),
        .zero     (mem_zero)
    );

`ifdef WB_MD_TIMEOUT_EN
    logic wd_zero, exc_tmo_q;

    wb_wait_counter #(.W(CNT_W)) u_wd_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     ((state != S_WAIT_MD) && (nxt == S_WAIT_MD)),
        .load_val (CNT_W'(MD_TIMEOUT - 1)),
        .dec      (state == S_WAIT_MD),
        .zero     (wd_zero)
    );

    assign wd_expire = (state == S_WAIT_MD) && wd_zero && !md_exit;
    assign exc_pend  = exc_div0_q || exc_ill_q || exc_tmo_q;
`else
    assign wd_expire = 1'b0;
    assign exc_pend  = exc_div0_q || exc_ill_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= DS_ALU;
            md_start_q  <= 1'b0;
            md_is_div_q <= 1'b0;
            exc_div0_q  <= 1'b0;
            exc_ill_q   <= 1'b0;
        end else begin
            state       <= nxt;
            if (accept)
                op_q <= wb_op;
            md_start_q  <= (state == S_LAUNCH);
            md_is_div_q <= (state == S_LAUNCH) && (op_q == OP_DIV);
            exc_div0_q  <= accept && (wb_op == OP_DIV) && divisor_zero;
            exc_ill_q   <= accept && (wb_op > OP_DIV);
        end
    end

`ifdef WB_MD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset)
            exc_tmo_q <= 1'b0;
        else
            exc_tmo_q <= wd_expire;
    end
`endif

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (wb_op)
                        OP_ALU, OP_SHIFT, OP_SLT, OP_LUI, OP_JAL: nxt = S_WRITE;
                        OP_LW, OP_LB, OP_LH:                      nxt = S_WAIT_MEM;
                        OP_MFLO, OP_MFHI: nxt = md_busy ? S_WAIT_MD : S_WRITE;
                        OP_MULT:          nxt = S_LAUNCH;
                        OP_DIV:           nxt = divisor_zero ? S_FIN : S_LAUNCH;
                        default:          nxt = S_FIN;
                    endcase
                end
            end
            S_WAIT_MEM: if (mem_zero) nxt = S_WRITE;
            S_WAIT_MD: begin
                if (md_exit)
                    nxt = is_md_read(op_q) ? S_WRITE : S_FIN;
                else if (wd_expire)
                    nxt = S_FIN;
            end
            S_LAUNCH: nxt = S_WAIT_MD;
            S_WRITE:  nxt = S_FIN;
            // an exception pulse occupies the first FIN cycle; done follows it
            S_FIN:    if (!exc_pend) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        data_src    = op_q;
        busy        = (state != S_IDLE);
        reg_write   = (state == S_WRITE);
        done        = (state == S_FIN) && !exc_pend;
        md_start    = md_start_q;
        md_is_div   = md_is_div_q;
        exc_div0    = exc_div0_q;
        exc_illegal = exc_ill_q;
`ifdef WB_MD_TIMEOUT_EN
        exc_md_timeout = exc_tmo_q;
`endif
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer: stimulus queues expected output pulses,
// a negedge monitor pops and compares each pulse the DUT presents.
module tb_wb_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] wb_op = 4'd0;
    logic       divisor_zero = 1'b0;
    logic       md_busy = 1'b0;
    logic       md_done = 1'b0;
    logic [3:0] data_src;
    logic       reg_write, md_start, md_is_div, busy, done, exc_div0, exc_illegal;
    logic       exc_md_timeout;

    localparam int K_WRITE = 0, K_DONE = 1, K_MDSTART = 2, K_DIV0 = 3, K_ILL = 4, K_TMO = 5;

    wb_sequencer #(.MEM_LAT(2), .MD_TIMEOUT(40)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .wb_op        (wb_op),
        .divisor_zero (divisor_zero),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .data_src     (data_src),
        .reg_write    (reg_write),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .busy         (busy),
        .done         (done),
        .exc_div0     (exc_div0),
        .exc_illegal  (exc_illegal)
`ifdef WB_MD_TIMEOUT_EN
        , .exc_md_timeout (exc_md_timeout)
`endif
    );

`ifndef WB_MD_TIMEOUT_EN
    assign exc_md_timeout = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  t0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_ev(input int kind, input int rel, input logic [3:0] val);
        ev_t e;
        e.kind = kind;
        e.cyc  = t0 + rel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [3:0] val);
        ev_t e;
        logic ok;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_pulse kind=%0d at cycle %0d, required none", kind, cyc);
        end else begin
            e  = exp_q.pop_front();
            ok = (e.kind == kind) && (e.cyc == cyc) &&
                 ((kind != K_WRITE && kind != K_MDSTART) || (e.val == val));
            if (ok) passes++;
            else $display("FAIL pulse actual kind=%0d cyc=%0d val=%0h required kind=%0d cyc=%0d val=%0h",
                          kind, cyc, val, e.kind, e.cyc, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (reg_write)      check_ev(K_WRITE, data_src);
        if (done)           check_ev(K_DONE, 4'd0);
        if (md_start)       check_ev(K_MDSTART, {3'd0, md_is_div});
        if (exc_div0)       check_ev(K_DIV0, 4'd0);
        if (exc_illegal)    check_ev(K_ILL, 4'd0);
        if (exc_md_timeout) check_ev(K_TMO, 4'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic dz);
        step();
        start = 1'b1;
        wb_op = op;
        divisor_zero = dz;
        t0 = cyc;
        step();
        start = 1'b0;
        divisor_zero = 1'b0;
    endtask

    task automatic wait_until(input int rel);
        while (cyc < t0 + rel) step();
    endtask

    task automatic drain(input int n, input string name);
        repeat (n) step();
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_idle_outputs(input string name);
        @(negedge clk);
        chk({name, "_data_src"}, data_src, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_reg_write"}, reg_write, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_md_start"}, md_start, 0);
        chk({name, "_md_is_div"}, md_is_div, 0);
        chk({name, "_exc_div0"}, exc_div0, 0);
        chk({name, "_exc_illegal"}, exc_illegal, 0);
    endtask

    initial begin
        repeat (3) step();
        chk_idle_outputs("reset");
        step();
        reset = 1'b0;

        // direct op: write at 1, done at 2, busy over 1-2
        issue(4'd0, 1'b0);
        expect_ev(K_WRITE, 1, 4'd0);
        expect_ev(K_DONE, 2, 4'd0);
        @(negedge clk); chk("alu_busy_c1", busy, 1);
        step(); @(negedge clk); chk("alu_busy_c2", busy, 1);
        step(); @(negedge clk); chk("alu_busy_c3", busy, 0);
        drain(3, "alu_drain");

        // load with MEM_LAT=2
        issue(4'd3, 1'b0);
        expect_ev(K_WRITE, 3, 4'd3);
        expect_ev(K_DONE, 4, 4'd0);
        drain(6, "lw_drain");

        // divide by zero: exception, no launch
        issue(4'd11, 1'b1);
        expect_ev(K_DIV0, 1, 4'd0);
        expect_ev(K_DONE, 2, 4'd0);
        drain(4, "div0_drain");

        // MULT completes at 34, no register write
        issue(4'd10, 1'b0);
        expect_ev(K_MDSTART, 2, 4'd0);
        expect_ev(K_DONE, 35, 4'd0);
        wait_until(34);
        md_done = 1'b1;
        step();
        md_done = 1'b0;
        drain(3, "mult_drain");

        // DIV launches the divider
        issue(4'd11, 1'b0);
        expect_ev(K_MDSTART, 2, 4'd1);
        expect_ev(K_DONE, 11, 4'd0);
        wait_until(10);
        md_done = 1'b1;
        step();
        md_done = 1'b0;
        drain(3, "div_drain");

        // MFHI with busy unit; second start mid-request ignored
        md_busy = 1'b1;
        issue(4'd2, 1'b0);
        expect_ev(K_WRITE, 6, 4'd2);
        expect_ev(K_DONE, 7, 4'd0);
        wait_until(3);
        start = 1'b1;
        wb_op = 4'd0;
        step();
        start = 1'b0;
        @(negedge clk); chk("mfhi_src_hold", data_src, 2);
        wait_until(5);
        md_busy = 1'b0;
        drain(4, "mfhi_drain");

        // MFLO with idle unit
        issue(4'd1, 1'b0);
        expect_ev(K_WRITE, 1, 4'd1);
        expect_ev(K_DONE, 2, 4'd0);
        drain(4, "mflo_drain");

        // illegal code
        issue(4'd13, 1'b0);
        expect_ev(K_ILL, 1, 4'd0);
        expect_ev(K_DONE, 2, 4'd0);
        drain(4, "ill_drain");

        // reset aborts a load with no write or done
        issue(4'd8, 1'b0);
        wait_until(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle_outputs("abort");
        drain(4, "abort_drain");
        issue(4'd5, 1'b0);
        expect_ev(K_WRITE, 1, 4'd5);
        expect_ev(K_DONE, 2, 4'd0);
        drain(4, "slt_drain");

        // start held through busy and FIN: next accept the cycle after done
        step();
        start = 1'b1;
        wb_op = 4'd6;
        t0 = cyc;
        step();
        wb_op = 4'd4;
        expect_ev(K_WRITE, 1, 4'd6);
        expect_ev(K_DONE, 2, 4'd0);
        expect_ev(K_WRITE, 4, 4'd4);
        expect_ev(K_DONE, 5, 4'd0);
        wait_until(4);
        start = 1'b0;
        drain(4, "backtoback_drain");

        // stray md_done outside WAIT_MD
        issue(4'd7, 1'b0);
        expect_ev(K_WRITE, 1, 4'd7);
        expect_ev(K_DONE, 2, 4'd0);
        md_done = 1'b1;
        step();
        md_done = 1'b0;
        drain(4, "stray_drain");

`ifdef WB_MD_TIMEOUT_EN
        issue(4'd10, 1'b0);
        expect_ev(K_MDSTART, 2, 4'd0);
        expect_ev(K_TMO, 42, 4'd0);
        expect_ev(K_DONE, 43, 4'd0);
        wait_until(46);
        chk("timeout_drain", exp_q.size(), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
